// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid, stall (hold) and flush (bubble) handling.
// Optional bubble counter enabled by defining BUBBLE_CNT_EN.
module id_ex_stage_reg #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_valid,
   input  logic [DATA_W-1:0]    i_read_rb_1,
   input  logic [DATA_W-1:0]    i_read_rb_2,
   input  logic [REG_W-1:0]     i_rt,
   input  logic [REG_W-1:0]     i_rd,
   input  logic [DATA_W-1:0]    i_address_pc,
   input  logic [DATA_W-1:0]    i_ext_sign,
   input  logic [DATA_W-1:0]    i_jump_address,
   input  logic [ALUOP_W+7:0]   i_ctrl,
   output logic                 o_valid,
   output logic [DATA_W-1:0]    o_read_rb_1,
   output logic [DATA_W-1:0]    o_read_rb_2,
   output logic [REG_W-1:0]     o_rt,
   output logic [REG_W-1:0]     o_rd,
   output logic [DATA_W-1:0]    o_address_pc,
   output logic [DATA_W-1:0]    o_ext_sign,
   output logic [DATA_W-1:0]    o_jump_address,
   output logic [ALUOP_W+7:0]   o_ctrl,
   output logic [CNT_W-1:0]     o_bubble_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] rb1;
      logic [DATA_W-1:0] rb2;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] ext;
      logic [DATA_W-1:0] jmp;
   } dp_t;

   // Field order gives branch at bit 0 and aluOp in the top bits.
   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic               jump;
      logic               reg_dst;
      logic               mem_to_reg;
      logic               reg_write;
      logic               alu_src;
      logic               mem_write;
      logic               mem_read;
      logic               branch;
   } ctrl_t;

   dp_t   dp_d, dp_q;
   ctrl_t ctrl_q;
   logic  vld_q;
   logic  load;

   assign load = ~i_flush & ~i_stall;

   assign dp_d = '{rb1: i_read_rb_1, rb2: i_read_rb_2, rt: i_rt, rd: i_rd,
                   pc: i_address_pc, ext: i_ext_sign, jmp: i_jump_address};

   // Datapath only moves on a load; flush leaves it alone since the
   // cleared valid/ctrl already neutralise whatever it holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_q <= '0;
      end else if (load) begin
         dp_q <= dp_d;
      end
   end

   // An upstream bubble must not carry side-effect bits, so ctrl is gated by valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         ctrl_q <= '0;
      end else if (i_flush) begin
         vld_q  <= 1'b0;
         ctrl_q <= '0;
      end else if (!i_stall) begin
         vld_q  <= i_valid;
         ctrl_q <= i_valid ? ctrl_t'(i_ctrl) : '0;
      end
   end

   assign o_valid        = vld_q;
   assign o_ctrl         = ctrl_q;
   assign o_read_rb_1    = dp_q.rb1;
   assign o_read_rb_2    = dp_q.rb2;
   assign o_rt           = dp_q.rt;
   assign o_rd           = dp_q.rd;
   assign o_address_pc   = dp_q.pc;
   assign o_ext_sign     = dp_q.ext;
   assign o_jump_address = dp_q.jmp;

`ifdef BUBBLE_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic             bubble_ld;

   assign bubble_ld = i_flush | (load & ~i_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (bubble_ld && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_bubble_cnt = cnt_q;
`else
   assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table, corner sequences
// and randomized traffic against a behavioural model.
module tb_id_ex_stage_reg;
   localparam int DW = 32, RW = 5, AW = 3, CW = 2, CTW = AW + 8;

   logic clk = 1'b0, rst_n = 1'b0;
   logic i_stall, i_flush, i_valid;
   logic [DW-1:0] i_read_rb_1, i_read_rb_2, i_address_pc, i_ext_sign, i_jump_address;
   logic [RW-1:0] i_rt, i_rd;
   logic [CTW-1:0] i_ctrl;
   logic o_valid;
   logic [DW-1:0] o_read_rb_1, o_read_rb_2, o_address_pc, o_ext_sign, o_jump_address;
   logic [RW-1:0] o_rt, o_rd;
   logic [CTW-1:0] o_ctrl;
   logic [CW-1:0] o_bubble_cnt;

   id_ex_stage_reg #(.DATA_W(DW), .REG_W(RW), .ALUOP_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
      .i_read_rb_1(i_read_rb_1), .i_read_rb_2(i_read_rb_2), .i_rt(i_rt), .i_rd(i_rd),
      .i_address_pc(i_address_pc), .i_ext_sign(i_ext_sign), .i_jump_address(i_jump_address),
      .i_ctrl(i_ctrl), .o_valid(o_valid), .o_read_rb_1(o_read_rb_1), .o_read_rb_2(o_read_rb_2),
      .o_rt(o_rt), .o_rd(o_rd), .o_address_pc(o_address_pc), .o_ext_sign(o_ext_sign),
      .o_jump_address(o_jump_address), .o_ctrl(o_ctrl), .o_bubble_cnt(o_bubble_cnt));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;

   // Reference state: what the stage should hold after each edge.
   logic m_valid;
   logic [DW-1:0] m_rb1, m_rb2, m_pc, m_ext, m_jmp;
   logic [RW-1:0] m_rt, m_rd;
   logic [CTW-1:0] m_ctrl;
   int m_cnt;

`ifdef BUBBLE_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_rb1 = 0; m_rb2 = 0; m_pc = 0; m_ext = 0; m_jmp = 0;
      m_rt = 0; m_rd = 0; m_ctrl = 0; m_cnt = 0;
   endtask

   task automatic bubble();
      if (m_cnt < (1 << CW) - 1) m_cnt++;
   endtask

   // Rules: flush wins and only kills valid/ctrl; stall freezes; load copies.
   task automatic model_edge();
      if (i_flush) begin
         m_valid = 0; m_ctrl = 0; bubble();
      end else if (!i_stall) begin
         m_rb1 = i_read_rb_1; m_rb2 = i_read_rb_2; m_rt = i_rt; m_rd = i_rd;
         m_pc = i_address_pc; m_ext = i_ext_sign; m_jmp = i_jump_address;
         m_valid = i_valid;
         m_ctrl = i_valid ? i_ctrl : '0;
         if (!i_valid) bubble();
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 64'(o_valid), 64'(m_valid));
      chk({tag, ".ctrl"}, 64'(o_ctrl), 64'(m_ctrl));
      chk({tag, ".rb1"}, 64'(o_read_rb_1), 64'(m_rb1));
      chk({tag, ".rb2"}, 64'(o_read_rb_2), 64'(m_rb2));
      chk({tag, ".rt"}, 64'(o_rt), 64'(m_rt));
      chk({tag, ".rd"}, 64'(o_rd), 64'(m_rd));
      chk({tag, ".pc"}, 64'(o_address_pc), 64'(m_pc));
      chk({tag, ".ext"}, 64'(o_ext_sign), 64'(m_ext));
      chk({tag, ".jmp"}, 64'(o_jump_address), 64'(m_jmp));
      chk({tag, ".cnt"}, 64'(o_bubble_cnt), CNT_ON ? 64'(m_cnt) : 64'd0);
      if (!o_valid) chk({tag, ".inv_ctrl"}, 64'(o_ctrl), 64'd0);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (rst_n) model_edge(); else model_reset();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic drive(input logic st, input logic fl, input logic v, input logic [DW-1:0] rb1,
                        input logic [DW-1:0] rb2, input logic [RW-1:0] rd,
                        input logic [DW-1:0] ext, input logic [CTW-1:0] ctrl);
      i_stall = st; i_flush = fl; i_valid = v; i_read_rb_1 = rb1; i_read_rb_2 = rb2;
      i_rd = rd; i_ext_sign = ext; i_ctrl = ctrl;
   endtask

   typedef struct {
      logic st, fl, v;
      logic [DW-1:0] rb1, rb2, ext;
      logic [RW-1:0] rd;
      logic [CTW-1:0] ctrl;
      logic e_v;
      logic [DW-1:0] e_rb1, e_rb2, e_ext;
      logic [RW-1:0] e_rd;
      logic [CTW-1:0] e_ctrl;
   } vec_t;

   vec_t vt[8];

   initial begin
      // st fl v   rb1       rb2       ext     rd   ctrl  | e_v e_rb1    e_rb2    e_ext  e_rd e_ctrl
      vt[0] = '{0,0,1, 32'h1234, 32'hAAAA, 32'h5,  5'd9,  11'h4D1, 1, 32'h1234, 32'hAAAA, 32'h5,  5'd9,  11'h4D1};
      vt[1] = '{1,0,1, 32'h1111, 32'hBBBB, 32'h6,  5'd17, 11'h7FF, 1, 32'h1234, 32'hAAAA, 32'h5,  5'd9,  11'h4D1};
      vt[2] = '{1,0,1, 32'h1111, 32'hBBBB, 32'h6,  5'd17, 11'h7FF, 1, 32'h1234, 32'hAAAA, 32'h5,  5'd9,  11'h4D1};
      vt[3] = '{1,0,1, 32'h1111, 32'hBBBB, 32'h6,  5'd17, 11'h7FF, 1, 32'h1234, 32'hAAAA, 32'h5,  5'd9,  11'h4D1};
      vt[4] = '{0,0,1, 32'h1111, 32'hBBBB, 32'h6,  5'd17, 11'h7FF, 1, 32'h1111, 32'hBBBB, 32'h6,  5'd17, 11'h7FF};
      vt[5] = '{1,1,1, 32'h9999, 32'hCCCC, 32'h8,  5'd3,  11'h7FF, 0, 32'h1111, 32'hBBBB, 32'h6,  5'd17, 11'h000};
      vt[6] = '{0,0,0, 32'h2222, 32'hDDDD, 32'h77, 5'd4,  11'h7FF, 0, 32'h2222, 32'hDDDD, 32'h77, 5'd4,  11'h000};
      vt[7] = '{1,0,1, 32'h3333, 32'hEEEE, 32'h99, 5'd5,  11'h7FF, 0, 32'h2222, 32'hDDDD, 32'h77, 5'd4,  11'h000};

      i_rt = 5'd7; i_address_pc = 32'h400; i_jump_address = 32'h800;
      drive(0, 0, 1, 32'hFFFF, 32'hFFFF, 5'd31, 32'hFFFF, 11'h7FF);
      model_reset();
      #1 check_all("rst_init");
      @(negedge clk); rst_n = 1;
      step("pre_load");

      // Async reset between edges while stalled with nonzero inputs.
      drive(1, 0, 1, 32'hABCD, 32'hABCD, 5'd30, 32'h1, 11'h7FF);
      #2 rst_n = 0;
      #1 model_reset(); check_all("rst_async");
      step("rst_held");
      rst_n = 1;
      #1 check_all("rst_released");

      for (int k = 0; k < 8; k++) begin
         drive(vt[k].st, vt[k].fl, vt[k].v, vt[k].rb1, vt[k].rb2, vt[k].rd, vt[k].ext, vt[k].ctrl);
         step($sformatf("vec%0d", k));
         chk($sformatf("vec%0d.tv", k), 64'(o_valid), 64'(vt[k].e_v));
         chk($sformatf("vec%0d.trb1", k), 64'(o_read_rb_1), 64'(vt[k].e_rb1));
         chk($sformatf("vec%0d.trb2", k), 64'(o_read_rb_2), 64'(vt[k].e_rb2));
         chk($sformatf("vec%0d.text", k), 64'(o_ext_sign), 64'(vt[k].e_ext));
         chk($sformatf("vec%0d.trd", k), 64'(o_rd), 64'(vt[k].e_rd));
         chk($sformatf("vec%0d.tctrl", k), 64'(o_ctrl), 64'(vt[k].e_ctrl));
      end

      // Counter saturation: 5 flushes then 2 stalls, then a reset pulse.
      rst_n = 0; #1 model_reset(); rst_n = 1;
      drive(0, 1, 1, 32'h5, 32'h6, 5'd1, 32'h7, 11'h7FF);
      for (int k = 0; k < 5; k++) step("sat_flush");
      drive(1, 0, 0, 32'h5, 32'h6, 5'd1, 32'h7, 11'h7FF);
      for (int k = 0; k < 2; k++) step("sat_stall");
      chk("sat_cnt", 64'(o_bubble_cnt), CNT_ON ? 64'd3 : 64'd0);
      rst_n = 0; #1 model_reset();
      chk("sat_rst", 64'(o_bubble_cnt), 64'd0);
      @(negedge clk); rst_n = 1;

      // Randomized traffic with occasional async reset pulses.
      for (int n = 0; n < 400; n++) begin
         i_stall = ($urandom % 4) == 0;
         i_flush = ($urandom % 8) == 0;
         i_valid = ($urandom % 5) != 0;
         i_read_rb_1 = $urandom; i_read_rb_2 = $urandom; i_address_pc = $urandom;
         i_ext_sign = $urandom; i_jump_address = $urandom;
         i_rt = RW'($urandom); i_rd = RW'($urandom); i_ctrl = CTW'($urandom);
         if (n % 97 == 50) begin
            #2 rst_n = 0;
            #1 model_reset(); check_all("rnd_rst");
            #1 rst_n = 1;
         end
         step("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_ex_stage_reg.md
Name:
id_ex_stage_reg

Overview:
Parametrised ID/EX pipeline register with per-stage valid, stall (hold) and flush (bubble insertion), sitting between decode and execute. Control-hazard flushes and load-use stalls are resolved here, so the hazard unit drives only two wires.

Parameters:
DATA_W, 32, width of operand, PC, sign-extended and jump-address fields
REG_W, 5, width of register-number fields rt/rd
ALUOP_W, 3, width of ALU opcode field inside the control bundle
CNT_W, 16, width of bubble counter (optional feature)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
i_stall  in  1  hold stage contents this cycle
i_flush  in  1  replace stage contents with bubble this cycle
i_valid  in  1  decode slot carries a real instruction
i_read_rb_1  in  DATA_W  register-file read port 1
i_read_rb_2  in  DATA_W  register-file read port 2
i_rt  in  REG_W  rt field
i_rd  in  REG_W  rd field
i_address_pc  in  DATA_W  PC+4 of instruction
i_ext_sign  in  DATA_W  sign-extended immediate
i_jump_address  in  DATA_W  jump target
i_ctrl  in  ALUOP_W+8  control bundle: [0]branch [1]memRead [2]memWrite [3]aluSrc [4]regWrite [5]memToReg [6]regDst [7]jump [ALUOP_W+7:8]aluOp
o_valid  out  1  stage holds a real instruction
o_read_rb_1  out  DATA_W  registered i_read_rb_1
o_read_rb_2  out  DATA_W  registered i_read_rb_2
o_rt  out  REG_W  registered i_rt
o_rd  out  REG_W  registered i_rd
o_address_pc  out  DATA_W  registered i_address_pc
o_ext_sign  out  DATA_W  registered i_ext_sign
o_jump_address  out  DATA_W  registered i_jump_address
o_ctrl  out  ALUOP_W+8  registered control bundle, same bit map as i_ctrl
o_bubble_cnt  out  CNT_W  bubbles loaded since reset (optional feature)

Behaviour:
- Reset (rst_n=0, immediate, no clock needed, including mid-stall): every output 0; o_valid=0; counter 0. Outputs remain 0 until the first rising edge with rst_n=1.
- Latency 1 cycle; one action per rising edge; priority flush > stall > load.
- Flush (i_flush=1, regardless of i_stall): o_valid<=0; o_ctrl<=0 (all control bits and aluOp zero); datapath outputs hold previous values.
- Stall (i_stall=1, i_flush=0): every output holds, o_valid included; inputs ignored.
- Load (both 0): all datapath fields captured; o_valid<=i_valid; o_ctrl<=i_ctrl if i_valid=1, else o_ctrl<=0 (upstream bubble never carries side-effect bits).
- Invariant: o_valid=0 implies o_ctrl=0 in every cycle.
- Stall held N cycles: outputs unchanged for all N edges; first edge after release loads the input then present.
- No width conversion; fields copied bit-exact.

Optional Feature:
BUBBLE_CNT_EN: defined -> o_bubble_cnt increments on each edge that loads a bubble (flush, or load with i_valid=0), saturates at 2^CNT_W-1, not affected by stall-only edges; undefined -> counter logic absent, o_bubble_cnt tied to 0.

Test Plan:
- Reset: rst_n=0 asserted between edges with nonzero inputs -> all outputs 0 immediately; first load after release with i_valid=1, i_read_rb_1=32'h1234, i_ctrl=11'h4D1 -> next edge o_valid=1, o_read_rb_1=32'h1234, o_ctrl=11'h4D1.
- Stall: load i_rd=5'd9, then i_stall=1 for 3 edges while i_rd=5'd17 -> o_rd stays 9 for 3 edges, becomes 17 on edge after release.
- Flush vs stall: stage holds i_ctrl=11'h7FF valid; i_flush=1 and i_stall=1 together -> next edge o_valid=0, o_ctrl=0, o_read_rb_2 unchanged.
- Upstream bubble: i_valid=0, i_ctrl=11'h7FF -> o_valid=0, o_ctrl=0, o_ext_sign=i_ext_sign.
- BUBBLE_CNT_EN, CNT_W=2: 5 flush edges plus 2 stall edges -> o_bubble_cnt reaches 3 and stays 3; rst_n pulse -> 0.
